// File: rtl/multi_bus_dut_pkg.sv
// Shared types and constants for the multi-channel bus target.
// Response data field is sized for the widest supported DATA_W (32).
package multi_bus_dut_pkg;
    localparam int XFER_CNT_W      = 16;
    localparam int RESP_DATA_MAX_W = 32;

    typedef enum logic {
        CMD_RD = 1'b0,
        CMD_WR = 1'b1
    } cmd_e;

    typedef struct packed {
        logic                       valid;
        logic                       err;
        logic [RESP_DATA_MAX_W-1:0] data;
    } resp_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after last_grant.
// Latency: combinational grant; pointer moves on the edge where advance is high.
// Backpressure: unserved requesters simply keep their req asserted.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(N - 1);

    logic [PTR_W-1:0] last_grant_q, last_grant_d;
    logic             found;
    int               idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 1; off <= N; off++) begin
            idx = (int'(last_grant_q) + off) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // Kept separate from the grant logic so advance (derived from gnt) forms no loop.
    always_comb begin
        last_grant_d = last_grant_q;
        for (int i = 0; i < N; i++) begin
            if (advance && gnt[i]) last_grant_d = PTR_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant_q <= PTR_RST;
        else        last_grant_q <= last_grant_d;
    end
endmodule

// File: rtl/multi_bus_dut.sv
// Multi-channel bus target sharing one register array via round-robin grant.
// Latency: one accept per cycle, response pulse exactly 1 cycle after accept.
// Backpressure: bus_ready is the grant; losers hold their request. Trace via MULTI_BUS_DUT_TRACE_EN.
module multi_bus_dut
    import multi_bus_dut_pkg::*;
#(
    parameter int NUM_BUS = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 256
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_BUS-1:0]             bus_valid,
    output logic [NUM_BUS-1:0]             bus_ready,
    input  logic [NUM_BUS-1:0]             bus_cmd,
    input  logic [NUM_BUS-1:0][ADDR_W-1:0] bus_addr,
    input  logic [NUM_BUS-1:0][DATA_W-1:0] bus_data,
    output logic [NUM_BUS-1:0]             resp_valid,
    output logic [NUM_BUS-1:0][DATA_W-1:0] resp_data,
    output logic [NUM_BUS-1:0]             resp_err,
    output logic [XFER_CNT_W-1:0]          xfer_count
);
    localparam int SEL_W = (NUM_BUS > 1) ? $clog2(NUM_BUS) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [NUM_BUS-1:0]    gnt;
    logic                  accept;
    logic [SEL_W-1:0]      sel;
    logic [ADDR_W-1:0]     sel_addr;
    logic [DATA_W-1:0]     sel_data, rd_data;
    logic                  sel_wr, in_range;
    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DATA_W-1:0]     mem_d [DEPTH];
    resp_t                 resp_q [NUM_BUS];
    resp_t                 resp_d [NUM_BUS];
    logic [XFER_CNT_W-1:0] xfer_count_q, xfer_count_d;

    // Requests are masked during reset so bus_ready stays low while rst_n is low.
    rr_arbiter #(.N(NUM_BUS)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus_valid & {NUM_BUS{rst_n}}),
        .advance (accept),
        .gnt     (gnt)
    );

    assign bus_ready = gnt;
    assign accept    = |gnt;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_BUS; i++) begin
            if (gnt[i]) sel = SEL_W'(i);
        end
        sel_addr = bus_addr[sel];
        sel_data = bus_data[sel];
        sel_wr   = (cmd_e'(bus_cmd[sel]) == CMD_WR);
        in_range = {1'b0, sel_addr} < DEPTH_L;
        rd_data  = in_range ? mem_q[sel_addr] : '0;
    end

    always_comb begin
        mem_d = mem_q;
        if (accept && sel_wr && in_range) mem_d[sel_addr] = sel_data;
    end

    always_comb begin
        for (int i = 0; i < NUM_BUS; i++) resp_d[i] = '0;
        if (accept) begin
            resp_d[sel].valid = 1'b1;
            resp_d[sel].err   = !in_range;
            resp_d[sel].data  = sel_wr ? '0 : RESP_DATA_MAX_W'(rd_data);
        end
        xfer_count_d = xfer_count_q + XFER_CNT_W'(accept);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            for (int i = 0; i < NUM_BUS; i++) resp_q[i] <= '0;
            xfer_count_q <= '0;
        end else begin
            mem_q        <= mem_d;
            resp_q       <= resp_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    for (genvar i = 0; i < NUM_BUS; i++) begin : g_resp
        assign resp_valid[i] = resp_q[i].valid;
        assign resp_err[i]   = resp_q[i].err;
        assign resp_data[i]  = resp_q[i].data[DATA_W-1:0];
    end

    assign xfer_count = xfer_count_q;

`ifdef MULTI_BUS_DUT_TRACE_EN
    always @(posedge clk) begin
        if (rst_n && accept)
            $display("@%4d ch%0d cmd=%s addr=%h data=%h err=%b", $time, sel,
                     sel_wr ? "W" : "R", sel_addr, sel_wr ? sel_data : rd_data, !in_range);
    end
`else
`endif
endmodule

// File: tb/tb_multi_bus_dut.sv
module tb_multi_bus_dut;
    localparam int NB = 2, AW = 8, DW = 8, DEP = 128;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NB-1:0]          bus_valid, bus_ready, bus_cmd;
    logic [NB-1:0][AW-1:0]  bus_addr;
    logic [NB-1:0][DW-1:0]  bus_data;
    logic [NB-1:0]          resp_valid, resp_err;
    logic [NB-1:0][DW-1:0]  resp_data;
    logic [15:0]            xfer_count;

    always #5 clk = ~clk;

    multi_bus_dut #(.NUM_BUS(NB), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP)) dut (
        .clk(clk), .rst_n(rst_n), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_cmd(bus_cmd), .bus_addr(bus_addr), .bus_data(bus_data),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .xfer_count(xfer_count)
    );

    int checks = 0, failures = 0;

    // Reference model: storage array, round-robin pointer, transfer counter.
    logic [DW-1:0] m_mem [DEP];
    int            m_last;
    logic [15:0]   m_cnt;

    // Expected/observed values produced by one clocked step.
    logic [NB-1:0]         e_rdy, got_rdy, e_rv, e_re;
    logic [NB-1:0][DW-1:0] e_rd;
    int                    last_g;

    task automatic model_reset();
        for (int i = 0; i < DEP; i++) m_mem[i] = '0;
        m_last = NB - 1;
        m_cnt  = 16'h0;
    endtask

    function automatic int model_grant(input logic [NB-1:0] v);
        for (int off = 1; off <= NB; off++)
            if (v[(m_last + off) % NB]) return (m_last + off) % NB;
        return -1;
    endfunction

    task automatic clear_req();
        bus_valid = '0; bus_cmd = '0; bus_addr = '0; bus_data = '0;
    endtask

    task automatic set_req(input int ch, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        bus_valid[ch] = 1'b1; bus_cmd[ch] = wr; bus_addr[ch] = a; bus_data[ch] = d;
    endtask

    // Called at a negedge with inputs set; returns at the next negedge.
    task automatic tick();
        int a;
        #1;
        last_g  = model_grant(bus_valid);
        e_rdy   = '0;
        if (last_g >= 0) e_rdy[last_g] = 1'b1;
        got_rdy = bus_ready;
        @(posedge clk);
        e_rv = '0; e_re = '0; e_rd = '0;
        if (last_g >= 0) begin
            a = int'(bus_addr[last_g]);
            e_rv[last_g] = 1'b1;
            e_re[last_g] = (a >= DEP);
            if (bus_cmd[last_g]) begin
                if (a < DEP) m_mem[a] = bus_data[last_g];
            end else if (a < DEP) begin
                e_rd[last_g] = m_mem[a];
            end
            m_last = last_g;
            m_cnt  = m_cnt + 16'd1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus_valid = NB'($urandom); bus_cmd = NB'($urandom);
            bus_addr = {$urandom, $urandom}; bus_data = {$urandom, $urandom};
            #1;
            checks++;
            if ({bus_ready, resp_valid, resp_err, resp_data, xfer_count} !== '0) begin
                failures++;
                $display("FAIL reset_outputs: got rdy=%b rv=%b err=%b data=%h cnt=%h, want all 0",
                         bus_ready, resp_valid, resp_err, resp_data, xfer_count);
            end
        end
        @(negedge clk);
        clear_req();
        rst_n = 1'b1;
        model_reset();
        set_req(1, 1'b0, 8'h10, 8'h00);
        tick();
        clear_req();
        checks++;
        if (got_rdy !== 2'b10) begin
            failures++; $display("FAIL reset_first_grant: got %b want 10", got_rdy);
        end
        checks++;
        if (resp_valid !== 2'b10 || resp_data[1] !== 8'h00 || resp_err[1] !== 1'b0) begin
            failures++;
            $display("FAIL reset_read10: got rv=%b data=%h err=%b want rv=10 data=00 err=0",
                     resp_valid, resp_data[1], resp_err[1]);
        end
    endtask

    task automatic test_write_read();
        set_req(0, 1'b1, 8'h3C, 8'hA5);
        tick();
        clear_req();
        checks++;
        if (got_rdy !== 2'b01 || resp_valid !== 2'b01 || resp_data[0] !== 8'h00) begin
            failures++;
            $display("FAIL wr_resp: got rdy=%b rv=%b data=%h want rdy=01 rv=01 data=00",
                     got_rdy, resp_valid, resp_data[0]);
        end
        set_req(1, 1'b0, 8'h3C, 8'h00);
        tick();
        clear_req();
        checks++;
        if (resp_valid !== 2'b10 || resp_data[1] !== 8'hA5 || resp_err !== 2'b00) begin
            failures++;
            $display("FAIL rd_after_wr: got rv=%b data=%h err=%b want rv=10 data=a5 err=00",
                     resp_valid, resp_data[1], resp_err);
        end
        tick();
        checks++;
        if (resp_valid !== 2'b00) begin
            failures++; $display("FAIL resp_one_pulse: got rv=%b want 00", resp_valid);
        end
    endtask

    task automatic test_contention();
        logic [1:0]  order [4];
        logic [7:0]  wa [4];
        logic [7:0]  wd [4];
        int          nxt [NB];
        logic [15:0] cnt0;
        order = '{2'b01, 2'b10, 2'b01, 2'b10};
        wa    = '{8'h20, 8'h22, 8'h21, 8'h23};  // ch0 uses [0..1], ch1 uses [2..3]
        for (int i = 0; i < 4; i++) wd[i] = 8'($urandom);
        cnt0 = xfer_count;
        nxt[0] = 0; nxt[1] = 0;
        set_req(0, 1'b1, wa[0], wd[0]);
        set_req(1, 1'b1, wa[2], wd[2]);
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (got_rdy !== order[c] || got_rdy !== e_rdy) begin
                failures++;
                $display("FAIL contention_grant%0d: got %b want %b", c, got_rdy, order[c]);
            end
            if (last_g >= 0) begin
                nxt[last_g]++;
                if (nxt[last_g] < 2)
                    set_req(last_g, 1'b1, wa[last_g*2 + nxt[last_g]], wd[last_g*2 + nxt[last_g]]);
                else
                    bus_valid[last_g] = 1'b0;
            end
        end
        clear_req();
        checks++;
        if (xfer_count !== cnt0 + 16'd4) begin
            failures++; $display("FAIL contention_count: got %h want %h", xfer_count, cnt0 + 16'd4);
        end
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1'b0, wa[i], 8'h00);
            tick();
            clear_req();
            checks++;
            if (resp_data[0] !== wd[i] || resp_valid !== 2'b01) begin
                failures++;
                $display("FAIL contention_landed%0d: got %h want %h", i, resp_data[0], wd[i]);
            end
        end
    endtask

    task automatic test_out_of_range();
        set_req(0, 1'b1, 8'h00, 8'h5A);
        tick();
        clear_req();
        set_req(1, 1'b1, 8'h80, 8'hFF);
        tick();
        clear_req();
        checks++;
        if (resp_valid !== 2'b10 || resp_err[1] !== 1'b1 || resp_data[1] !== 8'h00) begin
            failures++;
            $display("FAIL oor_write: got rv=%b err=%b data=%h want rv=10 err=1 data=00",
                     resp_valid, resp_err[1], resp_data[1]);
        end
        set_req(1, 1'b0, 8'h80, 8'h00);
        tick();
        clear_req();
        checks++;
        if (resp_valid !== 2'b10 || resp_err[1] !== 1'b1 || resp_data[1] !== 8'h00) begin
            failures++;
            $display("FAIL oor_read: got rv=%b err=%b data=%h want rv=10 err=1 data=00",
                     resp_valid, resp_err[1], resp_data[1]);
        end
        set_req(0, 1'b0, 8'h00, 8'h00);
        tick();
        clear_req();
        checks++;
        if (resp_data[0] !== 8'h5A || resp_err[0] !== 1'b0) begin
            failures++;
            $display("FAIL oor_addr0_intact: got %h err=%b want 5a err=0", resp_data[0], resp_err[0]);
        end
    endtask

    task automatic test_reset_mid();
        set_req(0, 1'b1, 8'h44, 8'h77);
        tick();
        clear_req();
        set_req(1, 1'b0, 8'h44, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        clear_req();
        #1;
        checks++;
        if (resp_valid !== 2'b00) begin
            failures++; $display("FAIL midrst_resp_dropped: got rv=%b want 00", resp_valid);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (resp_valid !== 2'b00 || xfer_count !== 16'h0) begin
                failures++;
                $display("FAIL midrst_after_release: got rv=%b cnt=%h want rv=00 cnt=0000",
                         resp_valid, xfer_count);
            end
        end
        set_req(0, 1'b0, 8'h44, 8'h00);
        tick();
        clear_req();
        checks++;
        if (resp_valid !== 2'b01 || resp_data[0] !== 8'h00) begin
            failures++;
            $display("FAIL midrst_array_cleared: got rv=%b data=%h want rv=01 data=00",
                     resp_valid, resp_data[0]);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] want [3];
        want = '{16'hFFFF, 16'h0000, 16'h0001};
        force dut.xfer_count_q = 16'hFFFE;
        #1;
        release dut.xfer_count_q;
        m_cnt = 16'hFFFE;
        set_req(1, 1'b1, 8'h05, 8'h11);
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (xfer_count !== want[c] || got_rdy !== 2'b10) begin
                failures++;
                $display("FAIL wrap%0d: got cnt=%h rdy=%b want cnt=%h rdy=10",
                         c, xfer_count, got_rdy, want[c]);
            end
        end
        clear_req();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int ch = 0; ch < NB; ch++) begin
                if (!bus_valid[ch] && $urandom_range(0, 99) < 60) begin
                    set_req(ch, 1'($urandom),
                            ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom),
                            8'($urandom));
                end else if (bus_valid[ch] && $urandom_range(0, 99) < 5) begin
                    bus_valid[ch] = 1'b0;
                end
            end
            tick();
            checks++;
            if (got_rdy !== e_rdy || resp_valid !== e_rv || resp_err !== e_re ||
                resp_data !== e_rd || xfer_count !== m_cnt) begin
                failures++;
                $display("FAIL random_c%0d: got rdy=%b rv=%b err=%b data=%h cnt=%h want rdy=%b rv=%b err=%b data=%h cnt=%h",
                         c, got_rdy, resp_valid, resp_err, resp_data, xfer_count,
                         e_rdy, e_rv, e_re, e_rd, m_cnt);
            end
            if (last_g >= 0) bus_valid[last_g] = 1'b0;
        end
        clear_req();
    endtask

    initial begin
        clear_req();
        rst_n = 1'b0;
        test_reset();
        test_write_read();
        test_contention();
        test_out_of_range();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
